// File: rtl/grf_trace.sv
// 32x32 register file with zero-cycle write forwarding and an 8-entry
// first-word-fall-through trace FIFO that logs every effective write.
module grf_trace (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  input  logic        WE,
  input  logic [4:0]  WA,
  input  logic [31:0] WD,
  input  logic [31:0] WPC,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data,
  output logic [3:0]  trace_count,
  output logic        trace_overflow
);

  localparam logic [3:0] DEPTH = 4'd8;

  logic [31:0] regs_q  [32];
  logic [31:0] fpc_q   [8];
  logic [4:0]  faddr_q [8];
  logic [31:0] fdata_q [8];

  logic [2:0] wptr_q, wptr_d;
  logic [2:0] rptr_q, rptr_d;
  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;

  logic wr_en, empty, full, pop, push;

  assign wr_en = WE && (WA != 5'd0);
  assign empty = (count_q == 4'd0);
  assign full  = (count_q == DEPTH);
  assign pop   = !empty && trace_ready;
  // A full FIFO still accepts a record when the head leaves in the same edge.
  assign push  = wr_en && (!full || pop);

  assign RD1 = (RA1 == 5'd0) ? 32'd0 : (wr_en && (WA == RA1)) ? WD : regs_q[RA1];
  assign RD2 = (RA2 == 5'd0) ? 32'd0 : (wr_en && (WA == RA2)) ? WD : regs_q[RA2];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q || (wr_en && full && !pop);
    if (push) wptr_d = wptr_q + 3'd1;
    if (pop)  rptr_d = rptr_q + 3'd1;
    if (push && !pop)      count_d = count_q + 4'd1;
    else if (pop && !push) count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (wr_en) begin
      regs_q[WA] <= WD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fpc_q[wptr_q]   <= WPC;
      faddr_q[wptr_q] <= WA;
      fdata_q[wptr_q] <= WD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= 3'd0;
      rptr_q  <= 3'd0;
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Empty FIFO presents all-zero head fields rather than stale storage.
  assign trace_valid    = !empty;
  assign trace_pc       = empty ? 32'd0 : fpc_q[rptr_q];
  assign trace_addr     = empty ? 5'd0  : faddr_q[rptr_q];
  assign trace_data     = empty ? 32'd0 : fdata_q[rptr_q];
  assign trace_count    = count_q;
  assign trace_overflow = ovf_q;

endmodule

// File: tb/tb_grf_trace.sv
// Bench for grf_trace: constant vector table, directed FIFO corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_grf_trace;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RA1, RA2, WA;
  logic [31:0] RD1, RD2, WD, WPC;
  logic        WE, trace_ready;
  logic        trace_valid, trace_overflow;
  logic [31:0] trace_pc, trace_data;
  logic [4:0]  trace_addr;
  logic [3:0]  trace_count;

  grf_trace dut (
    .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .WE(WE), .WA(WA), .WD(WD), .WPC(WPC),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_count(trace_count),
    .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus a record queue.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  a;
    logic [31:0] d;
  } rec_t;

  logic [31:0] m_regs [32];
  rec_t        mq [$];
  logic        m_ovf;

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    if (ra == 0) return 32'd0;
    if (WE && WA == ra) return WD;
    return m_regs[ra];
  endfunction

  task automatic check_model(input string tag);
    rec_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk({tag, "_rd1"},   RD1, m_read(RA1));
    chk({tag, "_rd2"},   RD2, m_read(RA2));
    chk({tag, "_valid"}, {31'd0, trace_valid}, {31'd0, mq.size() > 0});
    chk({tag, "_count"}, {28'd0, trace_count}, mq.size());
    chk({tag, "_ovf"},   {31'd0, trace_overflow}, {31'd0, m_ovf});
    chk({tag, "_pc"},    trace_pc, h.pc);
    chk({tag, "_addr"},  {27'd0, trace_addr}, {27'd0, h.a});
    chk({tag, "_data"},  trace_data, h.d);
  endtask

  // One clock edge; model follows the rules at the same edge.
  task automatic tick();
    logic do_pop, do_push;
    rec_t r;
    do_pop  = (mq.size() > 0) && trace_ready;
    do_push = WE && (WA != 0);
    r = '{pc: WPC, a: WA, d: WD};
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (do_push) m_regs[WA] = WD;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < 8) mq.push_back(r);
        else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] wpc, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic rdy);
    WE = we; WA = wa; WD = wd; WPC = wpc; RA1 = ra1; RA2 = ra2; trace_ready = rdy;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd, wpc;
    logic [4:0]  ra1, ra2;
    logic        rdy;
    logic [31:0] e_rd1, e_rd2;
    logic [3:0]  e_cnt;
    logic        e_vld, e_ovf;
    logic [31:0] e_pc;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [8];
  int   exp_a [8];

  initial begin
    tbl[0] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd3, 1'b0,
               32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0};
    tbl[1] = '{1'b1, 5'd5, 32'h1234, 32'h3000, 5'd5, 5'd0, 1'b0,
               32'h1234, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0};
    tbl[2] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b0,
               32'h1234, 32'h1234, 4'd1, 1'b1, 1'b0, 32'h3000, 5'd5, 32'h1234};
    tbl[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 32'h3004, 5'd0, 5'd0, 1'b0,
               32'h0, 32'h0, 4'd1, 1'b1, 1'b0, 32'h3000, 5'd5, 32'h1234};
    tbl[4] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd5, 1'b1,
               32'h0, 32'h1234, 4'd1, 1'b1, 1'b0, 32'h3000, 5'd5, 32'h1234};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd1, 1'b1,
               32'h1234, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0};
    tbl[6] = '{1'b1, 5'd7, 32'hAA, 32'h10, 5'd7, 5'd6, 1'b1,
               32'hAA, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0};
    tbl[7] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0, 1'b0,
               32'hAA, 32'h0, 4'd1, 1'b1, 1'b0, 32'h10, 5'd7, 32'hAA};
    exp_a = '{2, 3, 4, 5, 6, 7, 8, 10};

    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_ovf = 1'b0;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wpc, tbl[i].ra1, tbl[i].ra2, tbl[i].rdy);
      #1;
      chk($sformatf("tbl%0d_rd1", i), RD1, tbl[i].e_rd1);
      chk($sformatf("tbl%0d_rd2", i), RD2, tbl[i].e_rd2);
      chk($sformatf("tbl%0d_cnt", i), {28'd0, trace_count}, {28'd0, tbl[i].e_cnt});
      chk($sformatf("tbl%0d_vld", i), {31'd0, trace_valid}, {31'd0, tbl[i].e_vld});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, trace_overflow}, {31'd0, tbl[i].e_ovf});
      chk($sformatf("tbl%0d_pc", i), trace_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_addr", i), {27'd0, trace_addr}, {27'd0, tbl[i].e_addr});
      chk($sformatf("tbl%0d_data", i), trace_data, tbl[i].e_data);
      tick();
    end

    // Fill to 8, then overflow on the ninth write
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 32'hA0 + i, 32'h100 + i, 5'(i), 5'd0, 1'b0);
      #1 check_model("fill");
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("full_cnt", {28'd0, trace_count}, 32'd8);
    chk("full_ovf_pre", {31'd0, trace_overflow}, 32'd0);
    drive(1'b1, 5'd9, 32'h99, 32'h109, 5'd9, 5'd0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd1, 1'b0);
    #1;
    chk("ovf_set", {31'd0, trace_overflow}, 32'd1);
    chk("ovf_cnt", {28'd0, trace_count}, 32'd8);
    chk("ovf_head", {27'd0, trace_addr}, 32'd1);
    chk("ovf_reg9", RD1, 32'h99);
    check_model("ovf");

    // Push with pop while full
    drive(1'b1, 5'd10, 32'hB10, 32'h10A, 5'd0, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("pp_cnt", {28'd0, trace_count}, 32'd8);
    chk("pp_head", {27'd0, trace_addr}, 32'd2);
    chk("pp_ovf", {31'd0, trace_overflow}, 32'd1);

    // Drain in write order across pointer wrap
    trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("drain%0d_addr", k), {27'd0, trace_addr}, exp_a[k]);
      check_model("drain");
      tick();
    end
    #1;
    chk("empty_vld", {31'd0, trace_valid}, 32'd0);
    chk("empty_cnt", {28'd0, trace_count}, 32'd0);
    chk("empty_pc", trace_pc, 32'd0);
    chk("empty_addr", {27'd0, trace_addr}, 32'd0);
    chk("empty_data", trace_data, 32'd0);

    // Reset mid-operation with a write presented during reset
    for (int i = 11; i <= 15; i++) begin
      drive(1'b1, 5'(i), 32'hC0 + i, 32'h200 + i, 5'd0, 5'd0, 1'b0);
      tick();
    end
    #1;
    chk("pre_rst_cnt", {28'd0, trace_count}, 32'd5);
    chk("pre_rst_ovf", {31'd0, trace_overflow}, 32'd1);
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'hDEAD, 32'h300, 5'd0, 5'd0, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("rst_cnt", {28'd0, trace_count}, 32'd0);
    chk("rst_ovf", {31'd0, trace_overflow}, 32'd0);
    chk("rst_vld", {31'd0, trace_valid}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
      #1;
      chk($sformatf("rst_rd1_%0d", i), RD1, 32'd0);
      chk($sformatf("rst_rd2_%0d", i), RD2, 32'd0);
      tick();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa_r;
      reset = ($urandom_range(0, 99) == 0);
      wa_r  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 9) < 7, wa_r, $urandom, $urandom,
            ($urandom_range(0, 1) == 0) ? wa_r : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa_r : 5'($urandom_range(0, 31)),
            (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 6));
      #1 check_model("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
